// File: rtl/systolic_operand_feeder_pkg.sv
// Shared constants and FSM state encoding for the systolic operand feeder.
package systolic_operand_feeder_pkg;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned AXIS_W = 3;
   localparam int unsigned K_MAX  = 2 ** AXIS_W;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/feeder_operand_buf.sv
// K_MAX-deep operand register file: one write port, two combinational read ports.
// Each word packs {A[0][k], A[1][k], B[k][0], B[k][1]}.
module feeder_operand_buf #(
   parameter int unsigned DATA_W = systolic_operand_feeder_pkg::DATA_W,
   parameter int unsigned AXIS_W = systolic_operand_feeder_pkg::AXIS_W,
   parameter int unsigned K_MAX  = systolic_operand_feeder_pkg::K_MAX
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AXIS_W-1:0]   wr_addr,
   input  logic [4*DATA_W-1:0] wr_data,
   input  logic [AXIS_W-1:0]   rd0_addr,
   output logic [4*DATA_W-1:0] rd0_data,
   input  logic [AXIS_W-1:0]   rd1_addr,
   output logic [4*DATA_W-1:0] rd1_data
);
   import systolic_operand_feeder_pkg::*;

   logic [4*DATA_W-1:0] mem [K_MAX];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd0_data = mem[rd0_addr];
   assign rd1_data = mem[rd1_addr];
endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers 2xK / Kx2 operands and streams them skewed into a 2x2 systolic array,
// with per-PE clear strobes and a done pulse once all four results are final.
module systolic_operand_feeder #(
   parameter int unsigned DATA_W = systolic_operand_feeder_pkg::DATA_W,
   parameter int unsigned AXIS_W = systolic_operand_feeder_pkg::AXIS_W,
   parameter int unsigned K_MAX  = systolic_operand_feeder_pkg::K_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [AXIS_W-1:0] ld_k,
   input  logic [DATA_W-1:0] ld_a0,
   input  logic [DATA_W-1:0] ld_a1,
   input  logic [DATA_W-1:0] ld_b0,
   input  logic [DATA_W-1:0] ld_b1,
   input  logic              start,
   input  logic [AXIS_W-1:0] k_len,
   output logic [DATA_W-1:0] a1,
   output logic [DATA_W-1:0] a2,
   output logic [DATA_W-1:0] b1,
   output logic [DATA_W-1:0] b2,
   output logic              clear1,
   output logic              clear2,
   output logic              clear3,
   output logic              clear4,
   output logic              busy,
   output logic              done
);
   import systolic_operand_feeder_pkg::*;

   localparam int unsigned IW = AXIS_W + 1;
   localparam int unsigned OW = 4 * DATA_W;

   state_t            state, nxt_state;
   logic [IW-1:0]     t, nxt_t, k_cur;
   logic [AXIS_W-1:0] k_len_q, rd0_addr, rd1_addr;
   logic              wr_en;
   logic [OW-1:0]     wr_data, rd0_mem, rd1_mem, rd0, rd1;
   logic [DATA_W-1:0] n_a1, n_a2, n_b1, n_b2;
   logic              n_c1, n_c2, n_c3, n_c4;

   assign wr_en   = ld_valid && (state == IDLE);
   assign wr_data = {ld_a0, ld_a1, ld_b0, ld_b1};
   assign k_cur   = (state == IDLE) ? ({1'b0, k_len} + IW'(1)) : ({1'b0, k_len_q} + IW'(1));

   always_comb begin
      nxt_state = state;
      nxt_t     = t;
      case (state)
         IDLE:   if (start) begin nxt_state = STREAM; nxt_t = '0; end
         STREAM: begin
            nxt_t = t + IW'(1);
            if (t == k_cur) nxt_state = DRAIN;
         end
         DRAIN:  begin nxt_t = t + IW'(1); nxt_state = DONE; end
         DONE:   begin nxt_t = '0; nxt_state = IDLE; end
         default: begin nxt_t = '0; nxt_state = IDLE; end
      endcase
   end

   assign rd0_addr = nxt_t[AXIS_W-1:0];
   assign rd1_addr = rd0_addr - AXIS_W'(1);

   feeder_operand_buf #(.DATA_W(DATA_W), .AXIS_W(AXIS_W), .K_MAX(K_MAX)) u_buf (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_addr  (ld_k),
      .wr_data  (wr_data),
      .rd0_addr (rd0_addr),
      .rd0_data (rd0_mem),
      .rd1_addr (rd1_addr),
      .rd1_data (rd1_mem)
   );

   // Outputs are registered from next-state values, so a beat written on the start
   // cycle must be forwarded past the buffer to appear at t=0.
   assign rd0 = (wr_en && (ld_k == rd0_addr)) ? wr_data : rd0_mem;
   assign rd1 = (wr_en && (ld_k == rd1_addr)) ? wr_data : rd1_mem;

   always_comb begin
      n_a1 = '0;
      n_b1 = '0;
      n_a2 = '0;
      n_b2 = '0;
      n_c1 = 1'b0;
      n_c2 = 1'b0;
      n_c3 = 1'b0;
      n_c4 = 1'b0;
      if (nxt_state == STREAM) begin
         if (nxt_t < k_cur) begin
            n_a1 = rd0[OW-1 -: DATA_W];
            n_b1 = rd0[2*DATA_W-1 -: DATA_W];
         end
         if (nxt_t != '0) begin
            n_a2 = rd1[3*DATA_W-1 -: DATA_W];
            n_b2 = rd1[DATA_W-1:0];
         end
         n_c1 = (nxt_t == IW'(0));
         n_c2 = (nxt_t == IW'(1));
         n_c3 = (nxt_t == IW'(1));
      end
      if (nxt_state == STREAM || nxt_state == DRAIN) n_c4 = (nxt_t == IW'(2));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         t        <= '0;
         a1       <= '0;
         a2       <= '0;
         b1       <= '0;
         b2       <= '0;
         clear1   <= 1'b0;
         clear2   <= 1'b0;
         clear3   <= 1'b0;
         clear4   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ld_ready <= 1'b1;
      end else begin
         state    <= nxt_state;
         t        <= nxt_t;
         if (state == IDLE && start) k_len_q <= k_len;
         a1       <= n_a1;
         a2       <= n_a2;
         b1       <= n_b1;
         b2       <= n_b2;
         clear1   <= n_c1;
         clear2   <= n_c2;
         clear3   <= n_c3;
         clear4   <= n_c4;
         busy     <= (nxt_state == STREAM) || (nxt_state == DRAIN);
         done     <= (nxt_state == DONE);
         ld_ready <= (nxt_state == IDLE);
      end
   end
endmodule
